// File: rtl/onewire_slave.sv
// 1-wire bus slave: byte receive/transmit in master-timed slots, reset-pulse detection and
// presence pulse generation. The slave only ever pulls the line low or releases it.
module onewire_slave #(
    parameter int unsigned T_SAMPLE    = 30,
    parameter int unsigned T_HOLD      = 40,
    parameter int unsigned T_RESET_MIN = 240,
    parameter int unsigned T_PRES_WAIT = 15,
    parameter int unsigned T_PRES_LEN  = 60
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        port,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       bus_reset,
    output logic       busy
);

    localparam logic [9:0] CntMax    = 10'd1023;
    localparam logic [9:0] SampleC   = 10'(T_SAMPLE);
    localparam logic [9:0] HoldC     = 10'(T_HOLD);
    localparam logic [9:0] ResetC    = 10'(T_RESET_MIN);
    localparam logic [9:0] PresWaitC = 10'(T_PRES_WAIT);
    localparam logic [9:0] PresLenC  = 10'(T_PRES_LEN);
    // Lows shorter than this are glitches, not slots; real master lows are well above it.
    localparam logic [9:0] MinLowC   = 10'(T_SAMPLE / 4);

    typedef enum logic [2:0] {StIdle, StSlot, StRstLow, StPresWait, StPresence} state_e;

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, line_prev_q;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  low_cnt_q, low_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        bus_reset_q, bus_reset_d;
    logic [7:0]  tx_shreg_q, tx_shreg_d;
    logic [2:0]  tx_bit_cnt_q, tx_bit_cnt_d;
    logic        tx_ready_q, tx_ready_d;
    logic        slot_tx_q, slot_tx_d;
    logic        slot_bit_q, slot_bit_d;
    logic        line, fall, rst_hit, drive_low;
    logic [9:0]  cnt_inc;

    assign line    = sync2_q;
    assign fall    = line_prev_q & ~line;
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 10'd1;
    assign rst_hit = ((state_q == StSlot) && !line && (cnt_q == ResetC)) ||
                     (((state_q == StPresWait) || (state_q == StPresence)) &&
                      (low_cnt_q == ResetC));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            cnt_q        <= '0;
            low_cnt_q    <= '0;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            bus_reset_q  <= 1'b0;
            tx_shreg_q   <= '0;
            tx_bit_cnt_q <= '0;
            tx_ready_q   <= 1'b1;
            slot_tx_q    <= 1'b0;
            slot_bit_q   <= 1'b1;
        end else begin
            sync1_q      <= port;
            sync2_q      <= sync1_q;
            line_prev_q  <= sync2_q;
            cnt_q        <= cnt_d;
            low_cnt_q    <= low_cnt_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            bus_reset_q  <= bus_reset_d;
            tx_shreg_q   <= tx_shreg_d;
            tx_bit_cnt_q <= tx_bit_cnt_d;
            tx_ready_q   <= tx_ready_d;
            slot_tx_q    <= slot_tx_d;
            slot_bit_q   <= slot_bit_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        low_cnt_d    = line ? 10'd0 : ((low_cnt_q == CntMax) ? low_cnt_q : low_cnt_q + 10'd1);
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        bus_reset_d  = 1'b0;
        tx_shreg_d   = tx_shreg_q;
        tx_bit_cnt_d = tx_bit_cnt_q;
        tx_ready_d   = tx_ready_q;
        slot_tx_d    = slot_tx_q;
        slot_bit_d   = slot_bit_q;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    // Direction and bit value are frozen for the whole slot.
                    state_d    = StSlot;
                    cnt_d      = '0;
                    slot_tx_d  = ~tx_ready_q;
                    slot_bit_d = tx_shreg_q[7];
                end else if (tx_valid && tx_ready_q) begin
                    tx_shreg_d   = tx_data;
                    tx_bit_cnt_d = '0;
                    tx_ready_d   = 1'b0;
                end
            end
            StSlot: begin
                cnt_d = cnt_inc;
                if (line && (cnt_q < MinLowC)) begin
                    state_d = StIdle;
                end else if (line && (cnt_q > SampleC)) begin
                    state_d = StIdle;
                end else if (cnt_q == SampleC) begin
                    if (slot_tx_q) begin
                        tx_shreg_d   = {tx_shreg_q[6:0], 1'b0};
                        tx_bit_cnt_d = tx_bit_cnt_q + 3'd1;
                        if (tx_bit_cnt_q == 3'd7) begin
                            tx_ready_d = 1'b1;
                        end
                    end else begin
                        shreg_d   = {shreg_q[6:0], line};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {shreg_q[6:0], line};
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                        end
                    end
                end
            end
            StRstLow: begin
                if (line) begin
                    state_d = StPresWait;
                    cnt_d   = '0;
                end
            end
            StPresWait: begin
                cnt_d = cnt_inc;
                if (cnt_q == PresWaitC) begin
                    state_d = StPresence;
                    cnt_d   = '0;
                end
            end
            StPresence: begin
                cnt_d = cnt_inc;
                if (cnt_q == PresLenC) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst_hit) begin
            state_d      = StRstLow;
            bus_reset_d  = 1'b1;
            rx_valid_d   = 1'b0;
            shreg_d      = '0;
            bit_cnt_d    = '0;
            tx_bit_cnt_d = '0;
            tx_ready_d   = 1'b1;
        end
    end

    always_comb begin
        drive_low = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StSlot:     drive_low = slot_tx_q && !slot_bit_q && (cnt_q < HoldC);
            StPresence: drive_low = (cnt_q < PresLenC);
            default:    drive_low = 1'b0;
        endcase
    end

    assign port      = drive_low ? 1'b0 : 1'bz;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign bus_reset = bus_reset_q;

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a bus master model drives slots; expected rx bytes and bus resets
// are queued by a bit-level reference model and checked by an independent output monitor.
module tb_onewire_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire        port_w;
    logic       m_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       bus_reset;
    logic       busy;

    pullup (port_w);
    assign port_w = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    onewire_slave dut (
        .clk       (clk),
        .reset     (reset),
        .port      (port_w),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .bus_reset (bus_reset),
        .busy      (busy)
    );

    typedef struct packed {
        logic       is_rst;
        logic [7:0] data;
    } ev_t;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t exp_q[$];
    bit  model_bits[$];
    ev_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every 8 bits written since the last bus reset form one byte, MSB first.
    function automatic void model_bit(input bit b);
        logic [7:0] v;
        model_bits.push_back(b);
        if (model_bits.size() == 8) begin
            v = '0;
            for (int i = 0; i < 8; i++) v = {v[6:0], model_bits[i]};
            exp_q.push_back('{is_rst: 1'b0, data: v});
            model_bits.delete();
        end
    endfunction

    function automatic void model_reset();
        model_bits.delete();
        exp_q.push_back('{is_rst: 1'b1, data: 8'h00});
    endfunction

    always @(negedge clk) begin
        if (!reset && (rx_valid || bus_reset)) begin
            check("rx_valid and bus_reset exclusive", int'(rx_valid & bus_reset), 0);
            if (exp_q.size() == 0) begin
                check("unexpected output event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("event kind (1=bus_reset)", int'(bus_reset), int'(mon_e.is_rst));
                if (rx_valid && !mon_e.is_rst) check("rx_data", int'(rx_data), int'(mon_e.data));
            end
        end
    end

    task automatic write_bit(input bit b);
        model_bit(b);
        m_low = 1'b1;
        repeat (b ? 16 : 60) @(negedge clk);
        m_low = 1'b0;
        repeat (46) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
    endtask

    task automatic read_bit(output bit b);
        m_low = 1'b1;
        repeat (16) @(negedge clk);
        m_low = 1'b0;
        repeat (15) @(negedge clk);
        b = port_w;
        repeat (50) @(negedge clk);
    endtask

    task automatic read_byte(output logic [7:0] v);
        bit b;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            v = {v[6:0], b};
        end
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data  = v;
        tx_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!tx_ready) break;
        end
        check("tx handshake tx_ready low", int'(tx_ready), 0);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("return to idle", int'(busy), 0);
    endtask

    task automatic reset_pulse();
        int br_at, start, len;
        model_reset();
        br_at = -1;
        m_low = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (bus_reset && br_at < 0) br_at = i;
        end
        m_low = 1'b0;
        check("bus_reset at low cycle 240+sync", int'(br_at >= 240 && br_at <= 246), 1);
        start = -1;
        len   = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (port_w == 1'b0) begin
                if (start < 0) start = i;
                len++;
            end
        end
        check("presence start 15+sync after release", int'(start >= 15 && start <= 20), 1);
        check("presence length", len, 60);
        wait_idle();
    endtask

    initial begin
        logic [7:0] v, r;
        repeat (3) @(negedge clk);
        check("reset port released", int'(port_w), 1);
        check("reset tx_ready", int'(tx_ready), 1);
        check("reset rx_data", int'(rx_data), 0);
        check("reset rx_valid", int'(rx_valid), 0);
        check("reset bus_reset", int'(bus_reset), 0);
        check("reset busy", int'(busy), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        write_byte(8'hA5);
        for (int i = 0; i < 3; i++) write_byte(8'($urandom));

        load_tx(8'h3C);
        read_byte(r);
        check("master read 0x3C", int'(r), 8'h3C);
        check("tx_ready after 8th slot", int'(tx_ready), 1);
        for (int i = 0; i < 2; i++) begin
            v = 8'($urandom);
            load_tx(v);
            read_byte(r);
            check("master read random", int'(r), int'(v));
            check("tx_ready after random read", int'(tx_ready), 1);
        end

        reset_pulse();

        for (int i = 0; i < 3; i++) write_bit(1'($urandom));
        reset_pulse();
        write_byte(8'h81);

        m_low = 1'b1;
        repeat (5) @(negedge clk);
        m_low = 1'b0;
        repeat (40) @(negedge clk);
        check("idle after glitch", int'(busy), 0);
        write_byte(8'($urandom));

        load_tx({1'b0, 7'($urandom)});
        m_low = 1'b1;
        repeat (16) @(negedge clk);
        m_low = 1'b0;
        repeat (10) @(negedge clk);
        check("slave holds 0 bit", int'(port_w), 0);
        reset = 1'b1;
        #1;
        check("port released on reset", int'(port_w), 1);
        check("tx_ready on reset", int'(tx_ready), 1);
        check("busy on reset", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        model_bits.delete();
        repeat (5) @(negedge clk);
        write_byte(8'($urandom));

        repeat (10) @(negedge clk);
        check("pending expected outputs", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/onewire_slave.md
ONEWIRE_SLAVE -- requirements
Module: onewire_slave

Interface
REQ-001 SHALL have parameter T_SAMPLE, default 30: clk cycles after a detected falling edge at which a write-slot bit is sampled.
REQ-002 SHALL have parameter T_HOLD, default 40: clk cycles the slave holds the line low when transmitting a 0 bit.
REQ-003 SHALL have parameter T_RESET_MIN, default 240: minimum continuous low time, in clk cycles, recognised as a bus reset pulse.
REQ-004 SHALL have parameter T_PRES_WAIT, default 15: clk cycles from reset-pulse release to presence-pulse start.
REQ-005 SHALL have parameter T_PRES_LEN, default 60: presence-pulse length in clk cycles.
REQ-006 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port port, inout, 1: 1-wire bus line; the slave drives only 0 or high-Z, never 1.
REQ-009 SHALL have port tx_data, input, 8: byte to transmit in read slots.
REQ-010 SHALL have port tx_valid, input, 1: tx_data is valid.
REQ-011 SHALL have port tx_ready, output, 1: the slave can accept a byte.
REQ-012 SHALL have port rx_data, output, 8: last received byte.
REQ-013 SHALL have port rx_valid, output, 1: one-cycle pulse, rx_data updated.
REQ-014 SHALL have port bus_reset, output, 1: one-cycle pulse on reset-pulse recognition.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 SHALL sample port through a 2-flop synchronizer; "line" below means the synchronized value, and a falling edge is line 1 -> 0 between consecutive cycles.
REQ-017 SHALL implement states IDLE, SLOT, RST_LOW, PRES_WAIT, PRESENCE, using a 10-bit cycle counter cnt that saturates at 1023 and never wraps.
REQ-018 IDLE: on a falling edge, SHALL set cnt=0 and enter SLOT.
REQ-019 SLOT: SHALL increment cnt each cycle.
REQ-020 Transfer direction per slot: transmit if a tx byte is loaded (tx_ready=0), otherwise receive.
REQ-021 Receive slot: at cnt==T_SAMPLE, SHALL shift line into the shift register LSB side (shreg <= {shreg[6:0], line}) and increment the bit counter.
REQ-022 Receive: on the 8th bit, SHALL, in the next cycle, load rx_data with the full byte (first bit received = MSB), pulse rx_valid for one cycle, and clear the bit counter.
REQ-023 Transmit slot: SHALL take the current bit MSB first; if it is 0, drive port low while cnt<T_HOLD; if it is 1, keep port high-Z for the whole slot.
REQ-024 Transmit: at cnt==T_SAMPLE, SHALL advance to the next bit; after the 8th bit, SHALL set tx_ready=1.
REQ-025 tx handshake: the byte SHALL be accepted in a cycle with tx_valid=1 and tx_ready=1, only in state IDLE; tx_ready SHALL then go 0 in the next cycle.
REQ-026 SLOT exit: line==1 and cnt>T_SAMPLE SHALL return to IDLE; a slot ending before T_SAMPLE SHALL be ignored, with no bit taken.
REQ-027 Reset detection: in SLOT with line low, at cnt==T_RESET_MIN the slave SHALL release port, enter RST_LOW, pulse bus_reset for one cycle, and discard the partial rx byte and any loaded tx byte (bit counter=0, tx_ready=1).
REQ-028 RST_LOW: on line==1, SHALL set cnt=0 and enter PRES_WAIT.
REQ-029 PRES_WAIT: at cnt==T_PRES_WAIT, SHALL set cnt=0 and enter PRESENCE.
REQ-030 PRESENCE: SHALL drive port low while cnt<T_PRES_LEN, then release and enter IDLE; falling edges caused by its own drive SHALL NOT start a slot.
REQ-031 A new reset pulse (low for T_RESET_MIN) during PRES_WAIT or PRESENCE SHALL restart the sequence via RST_LOW; no tx_valid SHALL be accepted in these states.
REQ-032 rx_valid and bus_reset SHALL never be high in the same cycle.

Reset
REQ-033 While reset is high, outputs SHALL be: port high-Z, tx_ready=1, rx_data=0, rx_valid=0, bus_reset=0, busy=0; state=IDLE, cnt=0, bit counter=0, shift register=0, synchronizer=1.
REQ-034 Reset deassertion mid-slot SHALL resume in IDLE, waiting for the next falling edge.

Verification
REQ-035 Master write slots for 0xA5 (low 16 cycles for a 1, 60 cycles for a 0, slot 46 cycles) -> rx_valid pulses once with rx_data=0xA5.
REQ-036 Load tx_data=0x3C, then 8 master read slots (16-cycle low, sample at cycle 31) -> master reads 0x3C; tx_ready returns to 1 after the 8th slot.
REQ-037 Line low 300 cycles, then released -> bus_reset pulse at low cycle 240+sync; port low for 60 cycles starting 15 cycles after release.
REQ-038 Reset pulse after 3 bits of a receive byte, then 0x81 written -> only one rx_valid, with rx_data=0x81.
REQ-039 Glitch low for 5 cycles in IDLE -> no bit taken, no rx_valid, state back to IDLE.
REQ-040 Assert reset during a transmit 0-bit hold -> port high-Z immediately, tx_ready=1.
